// File: rtl/oserdes_lane_ctrl_if.sv
// Stream interface feeding one serializer lane: the source drives
// s_data/s_valid, the lane controller returns s_ready.
interface oserdes_lane_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/oserdes_lane_ctrl.sv
// Bring-up sequencer and word feeder for one OSERDESE2 output lane.
// Runs in the CLKDIV domain: holds the serializer in reset, lets it
// settle, emits a training word, then forwards stream data, substituting
// an idle word and counting each cycle the stream has nothing to give.
module oserdes_lane_ctrl #(
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    RST_CYCLES    = 4,
  parameter int                    SETTLE_CYCLES = 8,
  parameter int                    TRAIN_CYCLES  = 16,
  parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = DATA_WIDTH'(8'hF0),
  parameter logic [DATA_WIDTH-1:0] IDLE_PATTERN  = DATA_WIDTH'(8'h00),
  parameter int                    CNT_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  oserdes_lane_ctrl_if.slave    s,
  output logic [DATA_WIDTH-1:0] ser_d,
  output logic                  ser_rst,
  output logic                  ser_oce,
  output logic                  link_up,
  output logic [2:0]            state_o,
  output logic [CNT_WIDTH-1:0]  underflow_cnt,
  input  logic                  underflow_clr
);

  localparam int MAX_A = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int MAX_N = (MAX_A > TRAIN_CYCLES) ? MAX_A : TRAIN_CYCLES;
  localparam int PH_W  = (MAX_N > 1) ? $clog2(MAX_N) : 1;

  localparam logic [PH_W-1:0] RST_LD    = PH_W'(RST_CYCLES - 1);
  localparam logic [PH_W-1:0] SETTLE_LD = PH_W'(SETTLE_CYCLES - 1);
  localparam logic [PH_W-1:0] TRAIN_LD  = PH_W'(TRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RESET  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_TRAIN  = 3'd3,
    ST_RUN    = 3'd4
  } state_t;

  state_t          state;
  logic [PH_W-1:0] phase;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Control outputs come from the registered state only, so en/s_valid
  // never reach the serializer control pins combinationally.
  assign ser_rst   = (state == ST_IDLE) || (state == ST_RESET);
  assign ser_oce   = (state == ST_TRAIN) || (state == ST_RUN);
  assign link_up   = (state == ST_RUN);
  assign s.s_ready = (state == ST_RUN);
  assign state_o   = state;

  // Bring-up FSM; one shared down-counter times every timed state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      phase <= '0;
    end else if (state != ST_IDLE && !en) begin
      state <= ST_IDLE;
      phase <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en) begin
            state <= ST_RESET;
            phase <= RST_LD;
          end
        end
        ST_RESET: begin
          if (phase == '0) begin
            state <= ST_SETTLE;
            phase <= SETTLE_LD;
          end else begin
            phase <= phase - 1'b1;
          end
        end
        ST_SETTLE: begin
          if (phase == '0) begin
            state <= ST_TRAIN;
            phase <= TRAIN_LD;
          end else begin
            phase <= phase - 1'b1;
          end
        end
        ST_TRAIN: begin
          if (phase == '0) begin
            state <= ST_RUN;
            phase <= '0;
          end else begin
            phase <= phase - 1'b1;
          end
        end
        ST_RUN: begin
          state <= ST_RUN;
        end
        default: begin
          state <= ST_IDLE;
          phase <= '0;
        end
      endcase
    end
  end

  // Serializer word register: chosen by the current state, one cycle behind acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ser_d <= IDLE_PATTERN;
    end else begin
      case (state)
        ST_TRAIN: ser_d <= TRAIN_PATTERN;
        ST_RUN:   ser_d <= s.s_valid ? s.s_data : IDLE_PATTERN;
        default:  ser_d <= IDLE_PATTERN;
      endcase
    end
  end

  // Underflow counter: clear wins over increment; survives leaving RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow_cnt <= '0;
    end else if (underflow_clr) begin
      underflow_cnt <= '0;
    end else if (state == ST_RUN && !s.s_valid) begin
      underflow_cnt <= sat_inc(underflow_cnt);
    end
  end

endmodule

// File: tb/tb_oserdes_lane_ctrl.sv
// Bench for oserdes_lane_ctrl: directed bring-up, streaming, underflow,
// abort and async-reset steps, followed by a random phase, all compared
// against a timeline model of the lane (default counter width plus a
// second instance with a 4-bit counter for saturation).
module tb_oserdes_lane_ctrl;

  localparam int R = 4;
  localparam int S = 8;
  localparam int T = 16;
  localparam int RUN_T = R + S + T + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       underflow_clr;

  logic [7:0]  ser_d,  ser_d4;
  logic        ser_rst, ser_rst4, ser_oce, ser_oce4, link_up, link_up4;
  logic [2:0]  state_o, state_o4;
  logic [15:0] ucnt;
  logic [3:0]  ucnt4;

  oserdes_lane_ctrl_if #(.DATA_WIDTH(8)) sif ();
  oserdes_lane_ctrl_if #(.DATA_WIDTH(8)) sif4 ();
  assign sif4.s_data  = sif.s_data;
  assign sif4.s_valid = sif.s_valid;

  oserdes_lane_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .s(sif.slave),
    .ser_d(ser_d), .ser_rst(ser_rst), .ser_oce(ser_oce), .link_up(link_up),
    .state_o(state_o), .underflow_cnt(ucnt), .underflow_clr(underflow_clr)
  );

  oserdes_lane_ctrl #(.CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .s(sif4.slave),
    .ser_d(ser_d4), .ser_rst(ser_rst4), .ser_oce(ser_oce4), .link_up(link_up4),
    .state_o(state_o4), .underflow_cnt(ucnt4), .underflow_clr(underflow_clr)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: t = number of edges since en was sampled high (-1 when idle).
  int          m_t  = -1;
  logic [7:0]  m_d  = 8'h00;
  int          m_u  = 0;
  int          m_u4 = 0;

  function automatic int m_state(input int t);
    if (t < 0)          return 0;
    if (t <= R)         return 1;
    if (t <= R + S)     return 2;
    if (t <= R + S + T) return 3;
    return 4;
  endfunction

  task automatic model_reset();
    m_t = -1; m_d = 8'h00; m_u = 0; m_u4 = 0;
  endtask

  task automatic model_edge();
    int ps;
    ps = m_state(m_t);
    if (ps == 4)      m_d = sif.s_valid ? sif.s_data : 8'h00;
    else if (ps == 3) m_d = 8'hF0;
    else              m_d = 8'h00;
    if (underflow_clr) begin
      m_u = 0; m_u4 = 0;
    end else if (ps == 4 && !sif.s_valid) begin
      if (m_u  < 65535) m_u  = m_u + 1;
      if (m_u4 < 15)    m_u4 = m_u4 + 1;
    end
    if (m_t < 0)  m_t = en ? 1 : -1;
    else if (!en) m_t = -1;
    else if (m_t < RUN_T) m_t = m_t + 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int st;
    st = m_state(m_t);
    chk("state_o",  32'(state_o), 32'(st));
    chk("ser_rst",  32'(ser_rst), 32'(st <= 1));
    chk("ser_oce",  32'(ser_oce), 32'(st >= 3));
    chk("s_ready",  32'(sif.s_ready), 32'(st == 4));
    chk("link_up",  32'(link_up), 32'(st == 4));
    chk("ser_d",    32'(ser_d), 32'(m_d));
    chk("ucnt",     32'(ucnt), 32'(m_u));
    chk("state_o4", 32'(state_o4), 32'(st));
    chk("ucnt4",    32'(ucnt4), 32'(m_u4));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; underflow_clr = 1'b0;
    sif.s_valid = 1'b0; sif.s_data = 8'h00;
    model_reset();
    #12;
    check_outputs();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // Bring-up: RESET 1-4, SETTLE 5-12, TRAIN 13-28, RUN at 29.
    en = 1'b1;
    for (int e = 1; e <= RUN_T; e++) begin
      step();
      if (e == 4)  chk("reset_last",  32'(state_o), 32'd1);
      if (e == 5)  chk("settle_first", 32'(state_o), 32'd2);
      if (e == 13) chk("train_first", 32'(state_o), 32'd3);
      if (e == 20) chk("train_pat",   32'(ser_d), 32'hF0);
      if (e == 28) chk("train_last",  32'(state_o), 32'd3);
    end
    chk("run_link_up", 32'(link_up), 32'd1);

    // Stream 1..16 back to back.
    for (int k = 1; k <= 16; k++) begin
      sif.s_valid = 1'b1; sif.s_data = 8'(k);
      step();
      chk("stream_d", 32'(ser_d), 32'(k));
    end
    chk("stream_nounder", 32'(ucnt), 32'd0);

    // Five underflow cycles, then clear colliding with another underflow.
    sif.s_valid = 1'b0;
    for (int k = 0; k < 5; k++) step();
    chk("under5", 32'(ucnt), 32'd5);
    underflow_clr = 1'b1;
    step();
    chk("clr_prio", 32'(ucnt), 32'd0);
    underflow_clr = 1'b0;

    // 20 underflow cycles saturate the 4-bit counter.
    for (int k = 0; k < 20; k++) step();
    chk("sat4", 32'(ucnt4), 32'd15);
    chk("nosat16", 32'(ucnt), 32'd20);

    // en drop in RUN with a word presented: still accepted.
    sif.s_valid = 1'b1; sif.s_data = 8'hA5; en = 1'b0;
    step();
    chk("drop_accept", 32'(ser_d), 32'hA5);
    sif.s_valid = 1'b0;
    step();
    chk("drop_idle_d", 32'(ser_d), 32'h00);

    // Abort during TRAIN at edge 20, then full restart.
    en = 1'b1;
    for (int e = 1; e <= 20; e++) step();
    en = 1'b0;
    step();
    chk("abort_idle", 32'(state_o), 32'd0);
    en = 1'b1;
    for (int e = 1; e <= RUN_T; e++) step();
    chk("restart_run", 32'(state_o), 32'd4);

    // Random phase.
    for (int k = 0; k < 400; k++) begin
      sif.s_valid = ($urandom % 4) != 0;
      sif.s_data = 8'($urandom);
      underflow_clr = ($urandom % 32) == 0;
      if (en && ($urandom % 80) == 0) en = 1'b0;
      else if (!en && ($urandom % 4) == 0) en = 1'b1;
      step();
    end
    underflow_clr = 1'b0;

    // Get to RUN with some underflow, then async reset between edges.
    en = 1'b0; step();
    en = 1'b1; sif.s_valid = 1'b0;
    for (int e = 1; e <= RUN_T + 3; e++) step();
    sif.s_valid = 1'b1; sif.s_data = 8'h3C;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("async_d", 32'(ser_d), 32'h00);
    #2;
    rst_n = 1'b1;
    en = 1'b0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
